// File: rtl/ghostbus_host.sv
// ghostbus_host: valid/ready request stream to ghostbus cycle initiator.
// One transaction in flight; read data returned on a valid/ready response stream.

// Protocol invariants of the host, kept apart from the datapath.
module ghostbus_host_checker (
    input logic clk,
    input logic rst_n,
    input logic gb_we,
    input logic req_ready,
    input logic rsp_valid,
    input logic rsp_ready,
    input logic rsp_we,
    input logic [31:0] rsp_rdata
);

    // Write strobe is a single-cycle pulse.
    a_we_single: assert property (@(posedge clk) disable iff (!rst_n)
        gb_we |=> !gb_we);

    // Request and response sides are never open at the same time.
    a_ready_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(req_ready && rsp_valid));

    // A stalled response keeps its payload until consumed.
    a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_we) && $stable(rsp_rdata)));

endmodule

module ghostbus_host #(
    parameter int AW     = 12,
    parameter int DW     = 32,
    parameter int RD_LAT = 2
) (
    input  logic          gb_clk,
    input  logic          gb_rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_we,
    output logic [DW-1:0] rsp_rdata,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_dout,
    input  logic [DW-1:0] gb_din,
    output logic          gb_we
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_RWAIT = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Counter preload so that gb_din is sampled RD_LAT edges after gb_addr moves.
    localparam logic [3:0] LAT_INIT = 4'(RD_LAT - 1);

    state_t        state_r;
    logic [3:0]    lat_r;
    logic          req_ready_r;
    logic          rsp_valid_r;
    logic          rsp_we_r;
    logic [DW-1:0] rsp_rdata_r;
    logic [AW-1:0] gb_addr_r;
    logic [DW-1:0] gb_dout_r;
    logic          gb_we_r;

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge gb_clk or negedge gb_rst_n) begin
        if (!gb_rst_n) begin
            state_r     <= ST_IDLE;
            lat_r       <= 4'd0;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_we_r    <= 1'b0;
            rsp_rdata_r <= {DW{1'b0}};
            gb_addr_r   <= {AW{1'b0}};
            gb_dout_r   <= {DW{1'b0}};
            gb_we_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_ready_r && req_valid) begin
                        gb_addr_r   <= req_addr;
                        rsp_we_r    <= req_we;
                        req_ready_r <= 1'b0;
                        if (req_we) begin
                            gb_dout_r <= req_wdata;
                            gb_we_r   <= 1'b1;
                            state_r   <= ST_WRITE;
                        end else begin
                            lat_r   <= LAT_INIT;
                            state_r <= ST_RWAIT;
                        end
                    end else begin
                        // Opens on the first edge after reset release.
                        req_ready_r <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    gb_we_r     <= 1'b0;
                    rsp_rdata_r <= {DW{1'b0}};
                    rsp_valid_r <= 1'b1;
                    state_r     <= ST_RESP;
                end
                ST_RWAIT: begin
                    gb_we_r <= 1'b0;
                    if (lat_r == 4'd0) begin
                        rsp_rdata_r <= gb_din;
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_RESP;
                    end else begin
                        lat_r <= lat_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_valid_r && rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        rsp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    req_ready_r <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    gb_we_r     <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_we    = rsp_we_r;
    assign rsp_rdata = rsp_rdata_r;
    assign gb_addr   = gb_addr_r;
    assign gb_dout   = gb_dout_r;
    assign gb_we     = gb_we_r;

    ghostbus_host_checker u_checker (
        .clk       (gb_clk),
        .rst_n     (gb_rst_n),
        .gb_we     (gb_we_r),
        .req_ready (req_ready_r),
        .rsp_valid (rsp_valid_r),
        .rsp_ready (rsp_ready),
        .rsp_we    (rsp_we_r),
        .rsp_rdata (32'(rsp_rdata_r))
    );

endmodule

// File: tb/tb_ghostbus_host.sv
// Bench for ghostbus_host: three lanes with RD_LAT = 1, 2, 4, each driving its own
// host against a latency-matched peripheral model. Expected responses come from a
// reference memory and are queued at issue time; monitors pop and compare.
module tb_ghostbus_host;

    localparam int AW   = 12;
    localparam int DW   = 32;
    localparam int NTXN = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input int a);
        if (a == 0) return 32'h0000_0042;
        return 32'hA500_0000 + 32'(a) * 32'd769;
    endfunction

    for (genvar k = 0; k < 3; k++) begin : lane
        localparam int L  = (k == 0) ? 1 : ((k == 1) ? 2 : 4);
        localparam int PI = (L >= 2) ? (L - 2) : 0;

        logic          rst_n = 1'b0;
        logic          req_valid = 1'b0;
        logic          req_ready;
        logic          req_we = 1'b0;
        logic [AW-1:0] req_addr = '0;
        logic [DW-1:0] req_wdata = '0;
        logic          rsp_valid;
        logic          rsp_ready = 1'b0;
        logic          rsp_we;
        logic [DW-1:0] rsp_rdata;
        logic [AW-1:0] gb_addr;
        logic [DW-1:0] gb_dout;
        logic [DW-1:0] gb_din;
        logic          gb_we;

        int  rsp_mode = 1;
        bit  done = 1'b0;
        int  n_exp = 0, n_rsp = 0, n_wr = 0, n_pulse = 0, cyc = 0;

        logic [DW-1:0]    ref_mem [0:4095];
        logic [DW-1:0]    pmem    [0:4095];
        logic [DW-1:0]    pipe    [0:3];
        logic [DW:0]      rsp_q [$];
        logic [AW+DW-1:0] wr_q  [$];

        ghostbus_host #(.AW(AW), .DW(DW), .RD_LAT(L)) dut (
            .gb_clk    (clk),
            .gb_rst_n  (rst_n),
            .req_valid (req_valid),
            .req_ready (req_ready),
            .req_we    (req_we),
            .req_addr  (req_addr),
            .req_wdata (req_wdata),
            .rsp_valid (rsp_valid),
            .rsp_ready (rsp_ready),
            .rsp_we    (rsp_we),
            .rsp_rdata (rsp_rdata),
            .gb_addr   (gb_addr),
            .gb_dout   (gb_dout),
            .gb_din    (gb_din),
            .gb_we     (gb_we)
        );

        task automatic lchk(input string s, input logic [63:0] act, input logic [63:0] exp);
            chk($sformatf("rdlat%0d_%s", L, s), act, exp);
        endtask

        // Peripheral: memory with L-1 register stages on the read path.
        initial begin
            for (int i = 0; i < 4096; i++) pmem[i] = init_val(i);
            for (int i = 0; i < 4; i++) pipe[i] = '0;
            forever begin
                @(posedge clk);
                if (gb_we) pmem[gb_addr] <= gb_dout;
                pipe[0] <= pmem[gb_addr];
                for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
            end
        end
        assign gb_din = (L == 1) ? pmem[gb_addr] : pipe[PI];

        // Cycle counter, read only by the monitor on the falling edge.
        initial forever begin
            @(posedge clk);
            cyc++;
        end

        // Response-ready driver: 0 = hold low, 1 = always ready, 2 = random.
        initial forever begin
            @(posedge clk);
            #2;
            rsp_ready = (rsp_mode == 1) || ((rsp_mode == 2) && ($urandom_range(0, 3) != 0));
        end

        // Monitor: latency, response stability, scoreboard pops, write strobes.
        initial begin
            bit          pv = 1'b0, pc = 1'b0, pend = 1'b0, acc_we = 1'b0, pgw = 1'b0;
            logic        pwe = 1'b0;
            logic [DW-1:0] prd = '0;
            int          t_acc = 0;
            logic [DW:0] e;
            logic [AW+DW-1:0] w;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    pv = 1'b0; pc = 1'b0; pend = 1'b0; pgw = 1'b0;
                end else begin
                    if (req_valid && req_ready) begin
                        t_acc = cyc; acc_we = req_we; pend = 1'b1;
                    end
                    if (rsp_valid) begin
                        if (!pv || pc) begin
                            lchk("rsp_has_accept", 64'(pend), 64'd1);
                            if (pend) lchk("latency", 64'(cyc - t_acc), acc_we ? 64'd2 : 64'(L + 1));
                            pend = 1'b0;
                        end else begin
                            lchk("stall_rsp_we", 64'(rsp_we), 64'(pwe));
                            lchk("stall_rsp_rdata", 64'(rsp_rdata), 64'(prd));
                        end
                        if (rsp_ready) begin
                            n_rsp++;
                            lchk("rsp_expected", 64'(rsp_q.size() > 0), 64'd1);
                            if (rsp_q.size() > 0) begin
                                e = rsp_q.pop_front();
                                lchk("rsp_we", 64'(rsp_we), 64'(e[DW]));
                                lchk("rsp_rdata", 64'(rsp_rdata), 64'(e[DW-1:0]));
                            end
                        end
                    end else if (pv && !pc) begin
                        lchk("rsp_dropped", 64'(rsp_valid), 64'd1);
                    end
                    pv = rsp_valid; pc = rsp_ready; pwe = rsp_we; prd = rsp_rdata;
                    if (gb_we) begin
                        n_pulse++;
                        lchk("gb_we_single", 64'(pgw), 64'd0);
                        lchk("gb_we_expected", 64'(wr_q.size() > 0), 64'd1);
                        if (wr_q.size() > 0) begin
                            w = wr_q.pop_front();
                            lchk("gb_addr", 64'(gb_addr), 64'(w[AW+DW-1:DW]));
                            lchk("gb_dout", 64'(gb_dout), 64'(w[DW-1:0]));
                        end
                    end
                    pgw = gb_we;
                end
            end
        end

        // Offer one request and wait for acceptance; called and returns at posedge+1.
        task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input bit score);
            bit acc = 1'b0;
            req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
            for (int t = 0; t < 400 && !acc; t++) begin
                if (req_ready) begin
                    @(posedge clk);
                    acc = 1'b1;
                    if (score) begin
                        rsp_q.push_back({we, we ? 32'h0 : ref_mem[a]});
                        n_exp++;
                        if (we) begin
                            ref_mem[a] = d;
                            wr_q.push_back({a, d});
                            n_wr++;
                        end
                    end
                end else begin
                    @(posedge clk);
                end
                #1;
            end
            req_valid = 1'b0;
            if (!acc) lchk("accept_timeout", 64'(req_ready), 64'd1);
        endtask

        task automatic wait_idle();
            for (int t = 0; t < 1000 && n_rsp != n_exp; t++) begin
                @(posedge clk);
                #1;
            end
            lchk("idle_timeout", 64'(n_rsp), 64'(n_exp));
        endtask

        // Stimulus sequence for this lane.
        initial begin
            logic [DW-1:0] d2;
            logic [AW-1:0] a;
            int p0, ai;
            for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
            repeat (3) @(posedge clk);
            #1;
            lchk("rst_req_ready", 64'(req_ready), 64'd0);
            lchk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            lchk("rst_gb_addr", 64'(gb_addr), 64'd0);
            rst_n = 1'b1;
            #1;
            lchk("release_req_ready", 64'(req_ready), 64'd0);
            @(posedge clk);
            #1;
            lchk("first_edge_req_ready", 64'(req_ready), 64'd1);

            // Single write, then a read of a preset register.
            issue(1'b1, 12'h040, 32'hDEAD_BEEF, 1'b1);
            wait_idle();
            lchk("hold_gb_addr", 64'(gb_addr), 64'h040);
            issue(1'b0, 12'h000, 32'h0, 1'b1);
            wait_idle();
            lchk("read_keeps_dout", 64'(gb_dout), 64'hDEAD_BEEF);

            // Reset in the middle of a read: everything clears, no response follows.
            issue(1'b0, 12'h044, 32'h0, 1'b0);
            #2;
            rst_n = 1'b0;
            #1;
            lchk("mid_rst_gb_addr", 64'(gb_addr), 64'd0);
            lchk("mid_rst_gb_dout", 64'(gb_dout), 64'd0);
            lchk("mid_rst_gb_we", 64'(gb_we), 64'd0);
            lchk("mid_rst_req_ready", 64'(req_ready), 64'd0);
            lchk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
            lchk("mid_rst_rsp_we", 64'(rsp_we), 64'd0);
            lchk("mid_rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk);
                #1;
                lchk("no_rsp_after_rst", 64'(rsp_valid), 64'd0);
            end

            // Response back-pressure with a second request already offered.
            rsp_mode = 0;
            @(posedge clk);
            #1;
            d2 = $urandom;
            issue(1'b1, 12'h200, $urandom, 1'b1);
            p0 = n_pulse;
            req_we = 1'b1; req_addr = 12'h400; req_wdata = d2; req_valid = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk);
                #1;
                lchk("stall_req_ready", 64'(req_ready), 64'd0);
            end
            lchk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
            lchk("stall_one_pulse", 64'(n_pulse), 64'(p0 + 1));
            rsp_mode = 1;
            issue(1'b1, 12'h400, d2, 1'b1);
            wait_idle();
            issue(1'b0, 12'h200, 32'h0, 1'b1);
            issue(1'b0, 12'h400, 32'h0, 1'b1);
            wait_idle();

            // Random mix over the decoded address set.
            rsp_mode = 2;
            for (int n = 0; n < NTXN; n++) begin
                ai = $urandom_range(0, 9);
                a = (ai < 8) ? 12'(12'h040 + ai) : ((ai == 8) ? 12'h200 : 12'h400);
                issue(1'($urandom_range(0, 1)), a, $urandom, 1'b1);
                if ($urandom_range(0, 7) == 0) begin
                    repeat ($urandom_range(1, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
            rsp_mode = 1;
            wait_idle();
            lchk("pulse_count", 64'(n_pulse), 64'(n_wr));
            lchk("queue_drained", 64'(rsp_q.size()), 64'd0);
            done = 1'b1;
        end
    end

    initial begin
        for (int t = 0; t < 80000; t++) begin
            @(posedge clk);
            if (lane[0].done && lane[1].done && lane[2].done) break;
        end
        chk("global_timeout", {61'd0, lane[2].done, lane[1].done, lane[0].done}, 64'd7);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
